// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths.
// Used by the bridge, the APB slaves and the testbench.
package apb_pkg;

  localparam int APB_ADDR_W = 10;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_watchdog.sv
// Saturating ACCESS-phase wait counter.
// o_expire fires combinationally on the TIMEOUT_CYC-th stalled cycle; TIMEOUT_CYC=0 disables it.
module apb_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic pclk,
  input  logic presetn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [CW-1:0] MAX = CW'(TIMEOUT_CYC);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)                  r_cnt <= '0;
    else if (i_clr)                r_cnt <= '0;
    else if (i_en && r_cnt != MAX) r_cnt <= r_cnt + 1'b1;
  end

  // r_cnt stalled cycles already elapsed; this one would be number r_cnt+1
  assign o_expire = (TIMEOUT_CYC != 0) && i_en && (r_cnt == LIM);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready request port to APB master bridge, one transaction outstanding.
// All APB and response outputs are registered; req_ready decodes the state directly.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              psel,
  output logic              pen,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e        r_state, w_next;
  logic              r_psel, r_pen, r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_resp_valid, r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              w_accept, w_wait, w_expire;

  assign w_accept = (r_state == ST_IDLE) && req_valid;
  assign w_wait   = (r_state == ST_ACCESS) && !pready;

  apb_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .pclk     (pclk),
    .presetn  (presetn),
    .i_clr    (w_accept),
    .i_en     (w_wait),
    .o_expire (w_expire)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (req_valid) w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (pready || w_expire) w_next = ST_RESP;
      ST_RESP:   if (resp_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_psel       <= 1'b0;
      r_pen        <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_psel   <= 1'b1;
          r_pen    <= 1'b0;
          r_pwrite <= req_write;
          r_paddr  <= req_addr;
          r_pwdata <= req_wdata;
        end
        ST_SETUP: r_pen <= 1'b1;
        // a real pready beats a same-cycle timeout
        ST_ACCESS: if (pready || w_expire) begin
          r_psel       <= 1'b0;
          r_pen        <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= (pready && !r_pwrite) ? prdata : '0;
          r_resp_err   <= pready ? pslverr : 1'b1;
        end
        ST_RESP: if (resp_ready) r_resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign psel       = r_psel;
  assign pen        = r_pen;
  assign pwrite     = r_pwrite;
  assign paddr      = r_paddr;
  assign pwdata     = r_pwdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with TIMEOUT_CYC=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          pclk, presetn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready, resp_err;
  logic [DW-1:0] resp_rdata;
  logic          psel, pen, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;

  int checks   = 0;
  int failures = 0;

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(4)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .psel(psel), .pen(pen), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic test_reset();
    presetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0; prdata = '0; pready = 1'b1; pslverr = 1'b0;
    repeat (2) @(negedge pclk);
    checks++;
    if ({psel, pen, pwrite, paddr, pwdata, resp_valid, resp_rdata, resp_err} !== '0) begin
      failures++;
      $display("FAIL reset_outs got psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h rv=%b rd=%h err=%b exp all 0",
               psel, pen, pwrite, paddr, pwdata, resp_valid, resp_rdata, resp_err);
    end
    presetn = 1'b1;
    @(negedge pclk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_write();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'd0; req_wdata = 32'hA5A5_0001; pready = 1'b1;
    @(negedge pclk); // T1 SETUP
    req_valid = 1'b0;
    checks++;
    if ({psel, pen, pwrite, paddr, pwdata, req_ready} !== {1'b1, 1'b0, 1'b1, 10'd0, 32'hA5A5_0001, 1'b0}) begin
      failures++;
      $display("FAIL wr_setup got psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h rr=%b exp 1 0 1 000 a5a50001 0",
               psel, pen, pwrite, paddr, pwdata, req_ready);
    end
    @(negedge pclk); // T2 ACCESS
    checks++;
    if ({psel, pen, resp_valid} !== 3'b110) begin
      failures++; $display("FAIL wr_access got psel/pen/rv=%b%b%b exp=110", psel, pen, resp_valid);
    end
    @(negedge pclk); // T3 RESP
    checks++;
    if ({resp_valid, resp_err, resp_rdata, psel, pen} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL wr_resp got rv=%b err=%b rd=%h psel=%b pen=%b exp 1 0 0 0 0", resp_valid, resp_err, resp_rdata, psel, pen);
    end
    resp_ready = 1'b1;
    @(negedge pclk);
    resp_ready = 1'b0;
    checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      failures++; $display("FAIL wr_consume got rv=%b rr=%b exp rv=0 rr=1", resp_valid, req_ready);
    end
  endtask

  task automatic test_read();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd2; req_wdata = 32'h0; pready = 1'b1; prdata = 32'h1234_5678;
    @(negedge pclk);
    req_valid = 1'b0;
    checks++;
    if ({psel, pen, pwrite, paddr} !== {1'b1, 1'b0, 1'b0, 10'd2}) begin
      failures++; $display("FAIL rd_setup got psel=%b pen=%b pwrite=%b paddr=%h exp 1 0 0 002", psel, pen, pwrite, paddr);
    end
    @(negedge pclk);
    @(negedge pclk);
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h1234_5678}) begin
      failures++; $display("FAIL rd_resp got rv=%b err=%b rd=%h exp 1 0 12345678", resp_valid, resp_err, resp_rdata);
    end
    resp_ready = 1'b1;
    @(negedge pclk);
    resp_ready = 1'b0;
  endtask

  task automatic test_wait_states();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd3; pready = 1'b0; prdata = 32'hCAFE_BABE;
    @(negedge pclk); // SETUP
    req_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge pclk);
      checks++;
      if ({psel, pen, paddr, resp_valid} !== {1'b1, 1'b1, 10'd3, 1'b0}) begin
        failures++;
        $display("FAIL ws_access%0d got psel=%b pen=%b paddr=%h rv=%b exp 1 1 003 0", i, psel, pen, paddr, resp_valid);
      end
    end
    @(negedge pclk); // 4th ACCESS cycle, which also meets the watchdog limit
    checks++;
    if ({psel, pen, resp_valid} !== 3'b110) begin
      failures++; $display("FAIL ws_access4 got psel/pen/rv=%b%b%b exp=110", psel, pen, resp_valid);
    end
    pready = 1'b1;
    @(negedge pclk);
    checks++;
    if ({resp_valid, resp_err, resp_rdata, pen} !== {1'b1, 1'b0, 32'hCAFE_BABE, 1'b0}) begin
      failures++;
      $display("FAIL ws_resp got rv=%b err=%b rd=%h pen=%b exp 1 0 cafebabe 0", resp_valid, resp_err, resp_rdata, pen);
    end
    resp_ready = 1'b1;
    @(negedge pclk);
    resp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd5; pready = 1'b0; prdata = 32'hDEAD_BEEF;
    @(negedge pclk);
    req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge pclk);
      checks++;
      if ({psel, pen, resp_valid} !== 3'b110) begin
        failures++; $display("FAIL to_access%0d got psel/pen/rv=%b%b%b exp=110", i, psel, pen, resp_valid);
      end
    end
    @(negedge pclk);
    checks++;
    if ({resp_valid, resp_err, resp_rdata, psel, pen} !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL to_resp got rv=%b err=%b rd=%h psel=%b pen=%b exp 1 1 0 0 0", resp_valid, resp_err, resp_rdata, psel, pen);
    end
    resp_ready = 1'b1; pready = 1'b1;
    @(negedge pclk);
    resp_ready = 1'b0;
  endtask

  task automatic test_slverr_backpressure();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'd7; req_wdata = 32'h55; pready = 1'b1; pslverr = 1'b1;
    @(negedge pclk);
    req_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      failures++; $display("FAIL se_resp got rv=%b err=%b rd=%h exp 1 1 0", resp_valid, resp_err, resp_rdata);
    end
    pslverr = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd9;
    for (int i = 1; i <= 5; i++) begin
      @(negedge pclk);
      checks++;
      if ({resp_valid, resp_err, req_ready, psel} !== 4'b1100) begin
        failures++;
        $display("FAIL se_hold%0d got rv=%b err=%b rr=%b psel=%b exp 1 1 0 0", i, resp_valid, resp_err, req_ready, psel);
      end
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge pclk);
    resp_ready = 1'b0;
    checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      failures++; $display("FAIL se_release got rv=%b rr=%b exp rv=0 rr=1", resp_valid, req_ready);
    end
    @(negedge pclk);
    checks++;
    if ({psel, req_ready} !== 2'b01) begin
      failures++; $display("FAIL se_no_dup got psel=%b rr=%b exp psel=0 rr=1", psel, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd4; pready = 1'b0;
    @(negedge pclk);
    req_valid = 1'b0;
    @(negedge pclk);
    checks++;
    if ({psel, pen} !== 2'b11) begin failures++; $display("FAIL rm_access got psel/pen=%b%b exp=11", psel, pen); end
    #2 presetn = 1'b0;
    #1;
    checks++;
    if ({psel, pen, paddr} !== {1'b0, 1'b0, 10'd0}) begin
      failures++; $display("FAIL rm_async got psel=%b pen=%b paddr=%h exp 0 0 000", psel, pen, paddr);
    end
    @(negedge pclk);
    presetn = 1'b1; pready = 1'b1;
    @(negedge pclk);
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      failures++; $display("FAIL rm_release got rr=%b rv=%b exp rr=1 rv=0", req_ready, resp_valid);
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge pclk);
      checks++;
      if ({resp_valid, psel} !== 2'b00) begin
        failures++; $display("FAIL rm_quiet%0d got rv=%b psel=%b exp 0 0", i, resp_valid, psel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wait_states();
    test_timeout();
    test_slverr_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
